ex_stage_pipe: RTL
==================

Name: ex_stage_pipe

Overview:
- Parametrised, registered successor of the single-cycle execute stage.
- Performs operand select, ALU operation, branch-target add and destination-register select, then holds the results in an internal EX/MEM output register.
- Adds a valid/ready handshake toward decode and memory, plus an iterative multi-cycle multiplier that stalls upstream while it runs.
- Sits between the ID/EX register and the memory stage of the pipelined core.

Parameters:
XLEN, 32, datapath width of operands, immediate, PC and result
REG_AW, 5, register-index width for rt, rd and write_reg

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  stage accepts an operation this cycle
alu_src  input  1  0: operand B = rt_data; 1: operand B = imm
alu_op  input  2  00 add, 01 sub, 10 R-type (decode funct), 11 add
funct  input  6  R-type function code
pc_next  input  XLEN  PC+4 of the instruction
imm  input  XLEN  sign-extended immediate
rs_data  input  XLEN  operand A
rt_data  input  XLEN  rt register value
rt  input  REG_AW  rt index
rd  input  REG_AW  rd index
reg_dst  input  1  0: write_reg = rt; 1: write_reg = rd
out_valid  output  1  output register holds a result
out_ready  input  1  memory stage consumes the result
alu_res  output  XLEN  registered result
alu_zero  output  1  registered (alu_res == 0)
pc_branch  output  XLEN  registered pc_next + (imm << 2)
write_reg  output  REG_AW  registered destination index
busy  output  1  multiplier iterating

Behaviour:
- Reset (async, rst_n=0): out_valid=0, busy=0, alu_res=0, alu_zero=0, pc_branch=0, write_reg=0, FSM=IDLE. Reset mid-multiply abandons the operation; no result is produced.
- Ready rule: in_ready = (state==IDLE) & (~out_valid | out_ready). This is combinational and does not depend on in_valid.
- Accept: an operation is accepted when in_valid & in_ready.
- R-type decode by funct:
  - 0x20 add; 0x22 sub; 0x24 and; 0x25 or.
  - 0x2A slt: signed compare, result 1 or 0 zero-extended.
  - 0x18 mult: low XLEN bits of the product, with the macro enabled.
  - Any other funct: add.
- Operand B = alu_src ? imm : rt_data.
- Arithmetic is modulo 2^XLEN; no overflow flag or trap.
- pc_branch = pc_next + {imm[XLEN-3:0], 2'b00}, wraps modulo 2^XLEN. It is captured with every result, for every op.
- Single-cycle ops: accepted in cycle N; out_valid=1 with all outputs valid in cycle N+1 (latency 1).
- FSM states:
  - IDLE
    - accept of mult -> MUL: latch multiplicand, multiplier, pc_branch, write_reg; clear accumulator; count=XLEN; busy=1.
    - accept of any other op -> IDLE, output register loaded.
  - MUL
    - Each cycle: if multiplier LSB=1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count -= 1.
    - When count reaches 0 -> DONE.
  - DONE
    - Load the output register (out_valid=1) if ~out_valid | out_ready; otherwise wait in DONE.
    - On load -> IDLE, busy=0.
- Mult latency: accept in cycle N -> out_valid in cycle N+XLEN+1 when not back-pressured.
- Output hold: while out_valid & ~out_ready, all outputs remain stable and no new op is accepted.
- out_valid drops to 0 after out_ready=1 unless a new result loads in the same cycle. Back-to-back single-cycle ops sustain 1 per cycle when out_ready=1.
- Input values are ignored unless accepted.
- alu_zero is derived from the same value that is written into alu_res.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: funct 0x18 runs the iterative multiply as above; the MUL/DONE states exist.
- Undefined:
  - funct 0x18 completes in one cycle with alu_res=0 and alu_zero=1.
  - FSM is absent; busy is tied to 0.
  - in_ready = ~out_valid | out_ready.

Test Plan:
- Reset: rst_n=0 asserted mid-multiply (cycle 5 of 32) -> all outputs 0 and in_ready=1 after release; no stale out_valid.
- Single-cycle ALU, out_ready=1:
  - add 7+5 -> alu_res=12, alu_zero=0, latency 1.
  - sub 9-9 (alu_op=01) -> alu_res=0, alu_zero=1.
  - slt -1 vs 1 -> alu_res=1.
- Branch/dest select: pc_next=0x00000100, imm=0xFFFFFFFF -> pc_branch=0x000000FC. reg_dst=1, rd=17, rt=3 -> write_reg=17.
- Multiply (EX_MUL_EN), 0x0001_0003 × 0x0000_0005:
  - alu_res=0x0005_000F.
  - out_valid exactly 33 cycles after accept.
  - in_ready=0 and busy=1 throughout.
  - 0xFFFFFFFF × 2 -> 0xFFFFFFFE.
- Back-pressure: out_ready=0 for 4 cycles with result 12 held.
  - in_ready=0 and outputs stable during the stall.
  - On out_ready=1 the queued op loads the next cycle.
  - A stream of 5 adds with out_ready=1 gives 5 consecutive out_valid cycles.
- Macro off: funct 0x18 -> alu_res=0, alu_zero=1 with latency 1; busy never asserted.

Source files
------------

// File: rtl/ex_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe_if
// Purpose  : Bundle of handshake, operand and result signals between the
//            ID/EX register, the execute stage and the memory stage.
//            The master modport is the side that feeds operations and
//            consumes results; the slave modport is the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);

  // Upstream handshake and operation fields
  logic              in_valid;
  logic              in_ready;
  logic              alu_src;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs_data;
  logic [XLEN-1:0]   rt_data;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              reg_dst;

  // Downstream handshake and registered results
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_res;
  logic              alu_zero;
  logic [XLEN-1:0]   pc_branch;
  logic [REG_AW-1:0] write_reg;
  logic              busy;

  modport master (
    output in_valid, alu_src, alu_op, funct, pc_next, imm,
           rs_data, rt_data, rt, rd, reg_dst, out_ready,
    input  in_ready, out_valid, alu_res, alu_zero, pc_branch,
           write_reg, busy
  );

  modport slave (
    input  in_valid, alu_src, alu_op, funct, pc_next, imm,
           rs_data, rt_data, rt, rd, reg_dst, out_ready,
    output in_ready, out_valid, alu_res, alu_zero, pc_branch,
           write_reg, busy
  );

endinterface
`default_nettype wire

// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe
// Purpose  : Registered execute stage. Selects operand B, runs the ALU,
//            computes the branch target and destination register, and holds
//            the results in an EX/MEM output register behind a valid/ready
//            handshake.
//            Optional macro EX_MUL_EN: R-type funct 0x18 runs an iterative
//            shift-add multiplier (one multiplier bit per cycle) that stalls
//            upstream while it iterates. Without the macro, funct 0x18
//            completes in one cycle with a zero result and busy stays low.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_stage_pipe_if.slave bus
);

  // --------------------------------------------------------------------------
  // Combinational execute datapath
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]   w_op_b;
  logic [XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]   w_pc_branch;
  logic [REG_AW-1:0] w_write_reg;

  // Output-register control and load data
  logic              w_out_free;
  logic              w_in_ready;
  logic              w_busy;
  logic              w_load;
  logic [XLEN-1:0]   w_load_res;
  logic [XLEN-1:0]   w_load_pc;
  logic [REG_AW-1:0] w_load_wreg;

  // EX/MEM output register
  logic              r_out_valid;
  logic [XLEN-1:0]   r_alu_res;
  logic              r_alu_zero;
  logic [XLEN-1:0]   r_pc_branch;
  logic [REG_AW-1:0] r_write_reg;

  // Branch target wraps naturally modulo 2^XLEN; the top two imm bits are
  // shifted out by the word-offset scaling.
  assign w_pc_branch = bus.pc_next + {bus.imm[XLEN-3:0], 2'b00};
  assign w_write_reg = bus.reg_dst ? bus.rd : bus.rt;

  // The output register can take a new result when empty or being drained.
  assign w_out_free  = ~r_out_valid | bus.out_ready;

  // Single-cycle ALU: operand select then operation decode.
  always_comb begin
    w_op_b    = bus.alu_src ? bus.imm : bus.rt_data;
    w_alu_res = bus.rs_data + w_op_b;
    case (bus.alu_op)
      2'b01: w_alu_res = bus.rs_data - w_op_b;
      2'b10: begin
        case (bus.funct)
          6'h22:   w_alu_res = bus.rs_data - w_op_b;
          6'h24:   w_alu_res = bus.rs_data & w_op_b;
          6'h25:   w_alu_res = bus.rs_data | w_op_b;
          6'h2A:   w_alu_res = {{(XLEN-1){1'b0}},
                                ($signed(bus.rs_data) < $signed(w_op_b))};
          // Without the multiplier this is the architected result; with it,
          // the product comes from the iterative path and this is unused.
          6'h18:   w_alu_res = '0;
          default: w_alu_res = bus.rs_data + w_op_b;
        endcase
      end
      default: w_alu_res = bus.rs_data + w_op_b;
    endcase
  end

`ifdef EX_MUL_EN
  // --------------------------------------------------------------------------
  // Iterative multiplier control
  // --------------------------------------------------------------------------
  localparam int         CNT_W       = $clog2(XLEN + 1);
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_MUL    = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_mul_pc;
  logic [REG_AW-1:0] r_mul_wreg;
  logic [CNT_W-1:0]  r_count;
  logic [XLEN-1:0]   w_acc_step;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_last_step;

  assign w_is_mul    = (bus.alu_op == 2'b10) && (bus.funct == 6'h18);
  assign w_mul_start = bus.in_valid & w_in_ready & w_is_mul;
  assign w_acc_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // The step taken while count is 1 brings the count to zero, so the result
  // can be loaded straight from that step without an extra cycle.
  assign w_last_step = (r_count == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> MUL on a multiply, MUL -> IDLE/DONE on the
  // final step, DONE -> IDLE once the output register is free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_mul_start) w_state_nxt = c_ST_MUL;
      c_ST_MUL:  if (w_last_step) w_state_nxt = w_out_free ? c_ST_IDLE : c_ST_DONE;
      c_ST_DONE: if (w_out_free)  w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: handshake, busy and selection of what loads the result register.
  always_comb begin
    w_busy      = (r_state != c_ST_IDLE);
    w_in_ready  = (r_state == c_ST_IDLE) & w_out_free;
    w_load      = 1'b0;
    w_load_res  = w_alu_res;
    w_load_pc   = w_pc_branch;
    w_load_wreg = w_write_reg;
    case (r_state)
      c_ST_IDLE: w_load = bus.in_valid & w_in_ready & ~w_is_mul;
      c_ST_MUL: begin
        if (w_last_step & w_out_free) begin
          w_load      = 1'b1;
          w_load_res  = w_acc_step;
          w_load_pc   = r_mul_pc;
          w_load_wreg = r_mul_wreg;
        end
      end
      c_ST_DONE: begin
        w_load      = w_out_free;
        w_load_res  = r_acc;
        w_load_pc   = r_mul_pc;
        w_load_wreg = r_mul_wreg;
      end
      default: w_load = 1'b0;
    endcase
  end

  // Shift-add datapath: latch operands on start, one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_mul_pc   <= '0;
      r_mul_wreg <= '0;
      r_count    <= '0;
    end else if (r_state == c_ST_IDLE) begin
      if (w_mul_start) begin
        r_mcand    <= bus.rs_data;
        r_mplier   <= w_op_b;
        r_acc      <= '0;
        r_mul_pc   <= w_pc_branch;
        r_mul_wreg <= w_write_reg;
        r_count    <= CNT_W'(XLEN);
      end
    end else if (r_state == c_ST_MUL) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CNT_W'(1);
    end
  end
`else
  // --------------------------------------------------------------------------
  // No multiplier: every operation completes in one cycle.
  // --------------------------------------------------------------------------
  assign w_busy      = 1'b0;
  assign w_in_ready  = w_out_free;
  assign w_load      = bus.in_valid & w_out_free;
  assign w_load_res  = w_alu_res;
  assign w_load_pc   = w_pc_branch;
  assign w_load_wreg = w_write_reg;
`endif

  // EX/MEM output register: load a new result, or drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_res   <= '0;
      r_alu_zero  <= 1'b0;
      r_pc_branch <= '0;
      r_write_reg <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_alu_res   <= w_load_res;
      r_alu_zero  <= (w_load_res == '0);
      r_pc_branch <= w_load_pc;
      r_write_reg <= w_load_wreg;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.alu_res   = r_alu_res;
  assign bus.alu_zero  = r_alu_zero;
  assign bus.pc_branch = r_pc_branch;
  assign bus.write_reg = r_write_reg;

endmodule
`default_nettype wire
